button_event_gen: RTL

BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

---
 rtl/button_event_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 43 ++++
 rtl/button_event_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared FSM state type and default timing constants for a 100 MHz clock.
// BUTTON_DOUBLE_CLICK_EN adds the double-press states.
package button_event_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;    // 10 ms
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 300_000_000;  // 3 s
  localparam int unsigned DEFAULT_DCLICK_GAP_CYCLES = 30_000_000;   // 300 ms

`ifdef BUTTON_DOUBLE_CLICK_EN
  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } btn_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } btn_state_t;
`endif

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one
// raw push-button input.
module btn_debounce
  import button_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Level flips on the mismatching sample after DEBOUNCE_CYCLES counted ones,
  // so a steady input reaches level DEBOUNCE_CYCLES+2 edges after capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Push-button event generator: debounced level plus short/long press pulses.
// Define BUTTON_DOUBLE_CLICK_EN to add double-press detection.
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int unsigned DCLICK_GAP_CYCLES = DEFAULT_DCLICK_GAP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (DCLICK_GAP_CYCLES < 2) begin : g_bad_gap
    $error("DCLICK_GAP_CYCLES must be at least 2");
  end

  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);
  // The rise is observed in IDLE, so PRESSED needs LONG_PRESS_CYCLES-1 more
  // high samples; hold_cnt tops out at LONG_PRESS_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 2);

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (btn_in),
    .level(btn_level)
  );

  btn_state_t        state;
  btn_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              short_next;
  logic              long_next;

`ifdef BUTTON_DOUBLE_CLICK_EN
  localparam int unsigned GAP_W = $clog2(DCLICK_GAP_CYCLES);
  // Entry into WAIT_SECOND is one edge after the release, hence the -2.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DCLICK_GAP_CYCLES - 2);

  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_next;
  logic             double_next;
`else
  assign double_press = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
      gap_cnt      <= '0;
      double_press <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      short_press <= short_next;
      long_press  <= long_next;
`ifdef BUTTON_DOUBLE_CLICK_EN
      gap_cnt      <= gap_cnt_next;
      double_press <= double_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    short_next    = 1'b0;
    long_next     = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
    gap_cnt_next = gap_cnt;
    double_next  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (btn_level) begin
          state_next    = PRESSED;
          hold_cnt_next = '0;
        end
      end
      PRESSED: begin
        if (!btn_level) begin
`ifdef BUTTON_DOUBLE_CLICK_EN
          state_next   = WAIT_SECOND;
          gap_cnt_next = '0;
`else
          short_next = 1'b1;
          state_next = IDLE;
`endif
        end else if (hold_cnt == HOLD_LAST) begin
          long_next     = 1'b1;
          state_next    = LONG_HELD;
          hold_cnt_next = hold_cnt + 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_next = IDLE;
        end
      end
`ifdef BUTTON_DOUBLE_CLICK_EN
      WAIT_SECOND: begin
        if (btn_level) begin
          state_next    = SECOND_PRESSED;
          hold_cnt_next = '0;
        end else if (gap_cnt == GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (!btn_level) begin
          double_next = 1'b1;
          state_next  = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          long_next     = 1'b1;
          state_next    = LONG_HELD;
          hold_cnt_next = hold_cnt + 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
